// File: rtl/samp_pkg.sv
// Shared types and defaults for the sample-clock timebase.
package samp_pkg;

    localparam int ST_W          = 2;
    localparam int SAMP_DEF_HALF = 50;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/samp_div_core.sv
// Half-period divider: counter, active/pending ratio registers and samp_clk toggle.
// The active ratio only changes at a counter wrap (or while stopped), so phases never run short.
module samp_div_core #(
    parameter int CNT_W    = 32,
    parameter int DEF_HALF = 50
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_restart,
    input  logic             i_rise_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_div_half,
    output logic             o_samp_clk,
    output logic             o_rise,
    output logic             o_rise_nxt,
    output logic             o_fall_nxt
);

    localparam logic [CNT_W-1:0] ONE_C = 1;
    localparam logic [CNT_W-1:0] DEF_C = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend;
    logic             r_clk;
    logic             r_rise;

    logic [CNT_W-1:0] w_new_half;
    logic             w_tick;

    assign w_new_half = (i_div_half == '0) ? ONE_C : i_div_half;
    assign w_tick     = i_run && (r_cnt == r_half - ONE_C);
    assign o_rise_nxt = w_tick && !r_clk && i_rise_en;
    assign o_fall_nxt = w_tick && r_clk;
    assign o_samp_clk = r_clk;
    assign o_rise     = r_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_half <= DEF_C;
            r_pend <= DEF_C;
            r_clk  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_rise <= o_rise_nxt;
            if (i_load)
                r_pend <= w_new_half;
            // A load coinciding with the wrap governs the next half-period directly.
            if (!i_run || w_tick)
                r_half <= i_load ? w_new_half : r_pend;
            if (i_restart) begin
                r_cnt <= '0;
                r_clk <= 1'b0;
            end else if (i_run) begin
                if (w_tick) begin
                    r_cnt <= '0;
                    if (r_clk)
                        r_clk <= 1'b0;
                    else if (i_rise_en)
                        r_clk <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + ONE_C;
                end
            end
        end
    end

endmodule

// File: rtl/samp_timebase_gen.sv
// Sample-clock timebase: run/burst/flush control around samp_div_core,
// burst down-counter, sample index and completion strobe.
import samp_pkg::*;

module samp_timebase_gen #(
    parameter int CNT_W    = 32,
    parameter int LEN_W    = 16,
    parameter int DEF_HALF = SAMP_DEF_HALF
) (
    input  logic             i_sys_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_div_half,
    input  logic             i_div_load,
    input  logic             i_burst_mode,
    input  logic [LEN_W-1:0] i_burst_len,
    input  logic             i_start,
    input  logic             i_stop,
    output logic             o_samp_clk,
    output logic             o_samp_en,
    output logic [LEN_W-1:0] o_samp_idx,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [LEN_W-1:0] ONE_L = 1;

    state_t           r_state;
    logic [LEN_W-1:0] r_left;
    logic [LEN_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;

    logic w_run;
    logic w_start;
    logic w_rise_en;
    logic w_samp_clk;
    logic w_rise;
    logic w_rise_nxt;
    logic w_fall_nxt;

    assign w_run     = (r_state != ST_IDLE);
    assign w_start   = (r_state == ST_IDLE) && i_start;
    // No new high phase may begin once we are draining toward IDLE.
    assign w_rise_en = (r_state != ST_FLUSH);

    samp_div_core #(
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
    ) u_div (
        .i_clk      (i_sys_clk),
        .i_rst      (i_rst),
        .i_run      (w_run),
        .i_restart  (w_start),
        .i_rise_en  (w_rise_en),
        .i_load     (i_div_load),
        .i_div_half (i_div_half),
        .o_samp_clk (w_samp_clk),
        .o_rise     (w_rise),
        .o_rise_nxt (w_rise_nxt),
        .o_fall_nxt (w_fall_nxt)
    );

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_left  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_rise_nxt)
                r_idx <= r_idx + ONE_L;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_idx  <= '0;
                        r_left <= i_burst_len;
                        if (!i_burst_mode) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else if (i_burst_len != '0) begin
                            r_state <= ST_BURST;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_stop)
                        r_state <= ST_FLUSH;
                end
                ST_BURST: begin
                    if (w_rise_nxt)
                        r_left <= r_left - ONE_L;
                    if (i_stop || (w_rise_nxt && r_left == ONE_L))
                        r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (!w_samp_clk || w_fall_nxt) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_samp_clk = w_samp_clk;
    assign o_samp_en  = w_rise;
    assign o_samp_idx = r_idx;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_samp_timebase_gen.sv
// Directed bench for samp_timebase_gen: vector table plus hand-written long-run sequences.
module tb_samp_timebase_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] div_half;
    logic        div_load;
    logic        burst_mode;
    logic [15:0] burst_len;
    logic        start;
    logic        stop;
    logic        samp_clk;
    logic        samp_en;
    logic [15:0] samp_idx;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    samp_timebase_gen dut (
        .i_sys_clk    (clk),
        .i_rst        (rst),
        .i_div_half   (div_half),
        .i_div_load   (div_load),
        .i_burst_mode (burst_mode),
        .i_burst_len  (burst_len),
        .i_start      (start),
        .i_stop       (stop),
        .o_samp_clk   (samp_clk),
        .o_samp_en    (samp_en),
        .o_samp_idx   (samp_idx),
        .o_busy       (busy),
        .o_done       (done)
    );

    typedef struct {
        logic        st;
        logic        sp;
        logic        md;
        logic [15:0] len;
        logic        ld;
        logic [31:0] hf;
        logic        e_clk;
        logic        e_en;
        logic [15:0] e_idx;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic sp, logic md, logic [15:0] len, logic ld,
                                logic [31:0] hf, logic c, logic en, logic [15:0] idx,
                                logic b, logic d);
        vec_t v;
        v.st = st; v.sp = sp; v.md = md; v.len = len; v.ld = ld; v.hf = hf;
        v.e_clk = c; v.e_en = en; v.e_idx = idx; v.e_busy = b; v.e_done = d;
        return v;
    endfunction

    function automatic vec_t idle_step(logic c, logic en, logic [15:0] idx, logic b, logic d);
        return mk(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 32'd0, c, en, idx, b, d);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        div_half = 32'd0; div_load = 1'b0; burst_mode = 1'b0; burst_len = 16'd0;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load_half(input logic [31:0] h);
        div_half = h; div_load = 1'b1;
        tick();
        div_load = 1'b0; div_half = 32'd0;
    endtask

    task automatic do_start(input logic md, input logic [15:0] len);
        start = 1'b1; burst_mode = md; burst_len = len;
        tick();
        start = 1'b0; burst_mode = 1'b0; burst_len = 16'd0;
    endtask

    initial begin
        int  waited;
        logic saw_en;
        logic exp_c;

        clr_in();
        rst = 1'b1;
        tick();
        tick();
        chk("rst.clk",  samp_clk, 0);
        chk("rst.en",   samp_en,  0);
        chk("rst.idx",  samp_idx, 0);
        chk("rst.busy", busy,     0);
        chk("rst.done", done,     0);
        rst = 1'b0;
        tick();

        // T1: default H=50 continuous run
        do_start(1'b0, 16'd0);
        chk("t1.busy0", busy, 1);
        for (int e = 1; e <= 260; e++) begin
            tick();
            chk($sformatf("t1.clk@%0d", e), samp_clk, ((e / 50) % 2 == 1) ? 1 : 0);
            chk($sformatf("t1.en@%0d", e),  samp_en,  (e % 100 == 50) ? 1 : 0);
            if (e == 49 || e == 50 || e == 150 || e == 250)
                chk($sformatf("t1.idx@%0d", e), samp_idx, (e < 50) ? 0 : (e - 50) / 100 + 1);
        end
        // stop in the high phase that began at 250: done lands on the fall at 300
        stop = 1'b1;
        waited = 0;
        saw_en = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            stop = 1'b0;
            waited = k;
            if (samp_en) saw_en = 1'b1;
            if (done) break;
        end
        chk("t1.stop_wait", waited, 40);
        chk("t1.stop_done", done, 1);
        chk("t1.stop_clk", samp_clk, 0);
        chk("t1.stop_busy", busy, 0);
        chk("t1.stop_noen", saw_en, 0);

        // T2: H=10 burst, ratio 3 loaded mid high phase, then async reset (T5)
        load_half(32'd10);
        do_start(1'b1, 16'd100);
        for (int e = 1; e <= 36; e++) begin
            if (e == 13) begin
                div_half = 32'd3; div_load = 1'b1;
            end
            tick();
            div_load = 1'b0;
            exp_c = (e >= 10 && e < 20) || (e >= 23 && e < 26) || (e >= 29 && e < 32) || (e >= 35);
            chk($sformatf("t2.clk@%0d", e), samp_clk, exp_c);
        end
        chk("t2.idx", samp_idx, 4);
        #2;
        rst = 1'b1;
        #1;
        chk("t5.clk",  samp_clk, 0);
        chk("t5.idx",  samp_idx, 0);
        chk("t5.busy", busy,     0);
        chk("t5.done", done,     0);
        tick();
        rst = 1'b0;
        saw_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done || samp_en) saw_en = 1'b1;
        end
        chk("t5.quiet", saw_en, 0);
        do_start(1'b0, 16'd0);
        for (int e = 1; e <= 50; e++) begin
            tick();
            if (e == 49) chk("t5.clk@49", samp_clk, 0);
        end
        chk("t5.clk@50", samp_clk, 1);
        chk("t5.en@50",  samp_en,  1);
        chk("t5.idx@50", samp_idx, 1);
        pulse_rst();

        // T4: H=5, stop while high; high phase still lasts 5 cycles
        load_half(32'd5);
        do_start(1'b0, 16'd0);
        for (int e = 1; e <= 12; e++) begin
            stop = (e == 7);
            tick();
            stop = 1'b0;
            chk($sformatf("t4.clk@%0d", e), samp_clk, (e >= 5 && e < 10) ? 1 : 0);
            chk($sformatf("t4.done@%0d", e), done, (e == 10) ? 1 : 0);
            chk($sformatf("t4.busy@%0d", e), busy, (e < 10) ? 1 : 0);
        end
        saw_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (samp_en || samp_clk) saw_en = 1'b1;
        end
        chk("t4.no_rise", saw_en, 0);
        pulse_rst();

        // T3 (H=2 burst of 4) and T6 (H=0 -> 1, start+stop, zero-length burst)
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 4, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(idle_step(0, 0, 0, 1, 0));
        tbl.push_back(idle_step(1, 1, 1, 1, 0));
        tbl.push_back(idle_step(1, 0, 1, 1, 0));
        tbl.push_back(idle_step(0, 0, 1, 1, 0));
        tbl.push_back(idle_step(0, 0, 1, 1, 0));
        tbl.push_back(idle_step(1, 1, 2, 1, 0));
        tbl.push_back(idle_step(1, 0, 2, 1, 0));
        tbl.push_back(idle_step(0, 0, 2, 1, 0));
        tbl.push_back(idle_step(0, 0, 2, 1, 0));
        tbl.push_back(idle_step(1, 1, 3, 1, 0));
        tbl.push_back(idle_step(1, 0, 3, 1, 0));
        tbl.push_back(idle_step(0, 0, 3, 1, 0));
        tbl.push_back(idle_step(0, 0, 3, 1, 0));
        tbl.push_back(idle_step(1, 1, 4, 1, 0));
        tbl.push_back(idle_step(1, 0, 4, 1, 0));
        tbl.push_back(idle_step(0, 0, 4, 0, 1));
        tbl.push_back(idle_step(0, 0, 4, 0, 0));
        tbl.push_back(idle_step(0, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 4, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(idle_step(1, 1, 1, 1, 0));
        tbl.push_back(idle_step(0, 0, 1, 1, 0));
        tbl.push_back(idle_step(1, 1, 2, 1, 0));
        tbl.push_back(idle_step(0, 0, 2, 1, 0));
        tbl.push_back(idle_step(1, 1, 3, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3, 1, 0));
        tbl.push_back(idle_step(0, 0, 3, 0, 1));
        tbl.push_back(idle_step(0, 0, 3, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(idle_step(0, 0, 0, 0, 0));
        tbl.push_back(idle_step(0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            start = tbl[i].st; stop = tbl[i].sp; burst_mode = tbl[i].md;
            burst_len = tbl[i].len; div_load = tbl[i].ld; div_half = tbl[i].hf;
            tick();
            clr_in();
            chk($sformatf("tbl[%0d].clk", i),  samp_clk, tbl[i].e_clk);
            chk($sformatf("tbl[%0d].en", i),   samp_en,  tbl[i].e_en);
            chk($sformatf("tbl[%0d].idx", i),  samp_idx, tbl[i].e_idx);
            chk($sformatf("tbl[%0d].busy", i), busy,     tbl[i].e_busy);
            chk($sformatf("tbl[%0d].done", i), done,     tbl[i].e_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
